// File: rtl/hicore_rob_if.sv
// rtl/hicore_rob_if.sv - dispatch, writeback, commit and flush signals of the reorder buffer
interface hicore_rob_if #(
  parameter int DEPTH    = 4,
  parameter int RFIDX_W  = 5,
  parameter int CSRIDX_W = 12,
  parameter int REG_W    = 32,
  parameter int PC_W     = 32,
  parameter int IRQ_W    = 1,
  parameter int EXCP_W   = 4
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int WB_W  = PC_W + IRQ_W + EXCP_W;

  logic                disp_valid;
  logic                disp_ready;
  logic [TAG_W-1:0]    disp_tag;
  logic                disp_rd_need;
  logic [RFIDX_W-1:0]  disp_rd_idx;
  logic                disp_csr_need;
  logic [CSRIDX_W-1:0] disp_csr_idx;
  logic                disp_fence_i_op;
  logic                disp_mret_op;
  logic [PC_W-1:0]     disp_pc;
  logic [IRQ_W-1:0]    disp_irq;

  logic                wb_valid;
  logic [TAG_W-1:0]    wb_tag;
  logic [REG_W-1:0]    wb_rd_data;
  logic [REG_W-1:0]    wb_csr_data;
  logic [PC_W-1:0]     wb_next_pc;
  logic [EXCP_W-1:0]   wb_excp;

  logic                rob_valid;
  logic                rob_ready;
  logic                rob_rd_need;
  logic [RFIDX_W-1:0]  rob_rd_idx;
  logic [REG_W-1:0]    rob_rd_data;
  logic                rob_csr_need;
  logic [CSRIDX_W-1:0] rob_csr_idx;
  logic [REG_W-1:0]    rob_csr_data;
  logic                rob_fence_i_op;
  logic                rob_mret_op;
  logic [PC_W-1:0]     rob_next_pc;
  logic [WB_W-1:0]     rob_info;

  logic                flush;

  modport master (
    output disp_valid, disp_rd_need, disp_rd_idx, disp_csr_need, disp_csr_idx,
           disp_fence_i_op, disp_mret_op, disp_pc, disp_irq,
           wb_valid, wb_tag, wb_rd_data, wb_csr_data, wb_next_pc, wb_excp,
           rob_valid, flush,
    input  disp_ready, disp_tag,
           rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data, rob_csr_need, rob_csr_idx,
           rob_csr_data, rob_fence_i_op, rob_mret_op, rob_next_pc, rob_info
  );

  modport slave (
    input  disp_valid, disp_rd_need, disp_rd_idx, disp_csr_need, disp_csr_idx,
           disp_fence_i_op, disp_mret_op, disp_pc, disp_irq,
           wb_valid, wb_tag, wb_rd_data, wb_csr_data, wb_next_pc, wb_excp,
           rob_valid, flush,
    output disp_ready, disp_tag,
           rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data, rob_csr_need, rob_csr_idx,
           rob_csr_data, rob_fence_i_op, rob_mret_op, rob_next_pc, rob_info
  );
endinterface

// File: rtl/hicore_rob.sv
// rtl/hicore_rob.sv - in-order commit reorder buffer with out-of-order writeback
module hicore_rob #(
  parameter int DEPTH    = 4,
  parameter int RFIDX_W  = 5,
  parameter int CSRIDX_W = 12,
  parameter int REG_W    = 32,
  parameter int PC_W     = 32,
  parameter int IRQ_W    = 1,
  parameter int EXCP_W   = 4
) (
  input logic       clk,
  input logic       rst_n,
  hicore_rob_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] ent_valid, ent_done;
  logic [DEPTH-1:0] valid_nxt, done_nxt;

  logic                rd_need_q   [DEPTH];
  logic [RFIDX_W-1:0]  rd_idx_q    [DEPTH];
  logic                csr_need_q  [DEPTH];
  logic [CSRIDX_W-1:0] csr_idx_q   [DEPTH];
  logic                fence_i_q   [DEPTH];
  logic                mret_q      [DEPTH];
  logic [PC_W-1:0]     pc_q        [DEPTH];
  logic [IRQ_W-1:0]    irq_q       [DEPTH];
  logic [REG_W-1:0]    rd_data_q   [DEPTH];
  logic [REG_W-1:0]    csr_data_q  [DEPTH];
  logic [PC_W-1:0]     next_pc_q   [DEPTH];
  logic [EXCP_W-1:0]   excp_q      [DEPTH];

  logic disp_fire, commit_fire, wb_fire;

  assign bus.disp_ready = (count < FULL_CNT);
  assign bus.disp_tag   = tail;
  assign bus.rob_ready  = ent_valid[head] & ent_done[head];

  assign disp_fire   = bus.disp_valid & bus.disp_ready;
  assign commit_fire = bus.rob_valid & bus.rob_ready;
  // A writeback aimed at the slot being allocated this cycle belongs to a stale instruction.
  assign wb_fire     = bus.wb_valid & ent_valid[bus.wb_tag] &
                       ~(disp_fire & (bus.wb_tag == tail));

  always_comb begin
    valid_nxt = ent_valid;
    done_nxt  = ent_done;
    if (wb_fire) done_nxt[bus.wb_tag] = 1'b1;
    if (commit_fire) begin
      valid_nxt[head] = 1'b0;
      done_nxt[head]  = 1'b0;
    end
    if (disp_fire) begin
      valid_nxt[tail] = 1'b1;
      done_nxt[tail]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (bus.flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      ent_valid <= valid_nxt;
      ent_done  <= done_nxt;
      if (commit_fire) head <= head + 1'b1;
      if (disp_fire)   tail <= tail + 1'b1;
      case ({disp_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatch and writeback touch disjoint fields, so both may land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_need_q[i]  <= '0;
        rd_idx_q[i]   <= '0;
        csr_need_q[i] <= '0;
        csr_idx_q[i]  <= '0;
        fence_i_q[i]  <= '0;
        mret_q[i]     <= '0;
        pc_q[i]       <= '0;
        irq_q[i]      <= '0;
        rd_data_q[i]  <= '0;
        csr_data_q[i] <= '0;
        next_pc_q[i]  <= '0;
        excp_q[i]     <= '0;
      end
    end else if (!bus.flush) begin
      if (disp_fire) begin
        rd_need_q[tail]  <= bus.disp_rd_need;
        rd_idx_q[tail]   <= bus.disp_rd_idx;
        csr_need_q[tail] <= bus.disp_csr_need;
        csr_idx_q[tail]  <= bus.disp_csr_idx;
        fence_i_q[tail]  <= bus.disp_fence_i_op;
        mret_q[tail]     <= bus.disp_mret_op;
        pc_q[tail]       <= bus.disp_pc;
        irq_q[tail]      <= bus.disp_irq;
      end
      if (wb_fire) begin
        rd_data_q[bus.wb_tag]  <= bus.wb_rd_data;
        csr_data_q[bus.wb_tag] <= bus.wb_csr_data;
        next_pc_q[bus.wb_tag]  <= bus.wb_next_pc;
        excp_q[bus.wb_tag]     <= bus.wb_excp;
      end
    end
  end

  assign bus.rob_rd_need    = rd_need_q[head];
  assign bus.rob_rd_idx     = rd_idx_q[head];
  assign bus.rob_rd_data    = rd_data_q[head];
  assign bus.rob_csr_need   = csr_need_q[head];
  assign bus.rob_csr_idx    = csr_idx_q[head];
  assign bus.rob_csr_data   = csr_data_q[head];
  assign bus.rob_fence_i_op = fence_i_q[head];
  assign bus.rob_mret_op    = mret_q[head];
  assign bus.rob_next_pc    = next_pc_q[head];
  assign bus.rob_info       = {pc_q[head], irq_q[head], excp_q[head]};
endmodule

// File: tb/tb_hicore_rob.sv
// tb/tb_hicore_rob.sv - randomized and directed checks of hicore_rob against an in-order queue model
module tb_hicore_rob;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  hicore_rob_if #(.DEPTH(DEPTH)) bus ();

  hicore_rob #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        rd_need;
    logic [4:0]  rd_idx;
    logic        csr_need;
    logic [11:0] csr_idx;
    logic        fence_i;
    logic        mret;
    logic [31:0] pc;
    logic        irq;
    logic [31:0] rd_data;
    logic [31:0] csr_data;
    logic [31:0] next_pc;
    logic [3:0]  excp;
    bit          done;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    bit exp_ready;
    exp_ready = (mq.size() > 0) && mq[0].done;
    check("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < DEPTH));
    check("disp_tag", 64'(bus.disp_tag), 64'(m_tail));
    check("rob_ready", 64'(bus.rob_ready), 64'(exp_ready));
    if (exp_ready) begin
      check("rob_rd_need", 64'(bus.rob_rd_need), 64'(mq[0].rd_need));
      check("rob_rd_idx", 64'(bus.rob_rd_idx), 64'(mq[0].rd_idx));
      check("rob_rd_data", 64'(bus.rob_rd_data), 64'(mq[0].rd_data));
      check("rob_csr_need", 64'(bus.rob_csr_need), 64'(mq[0].csr_need));
      check("rob_csr_idx", 64'(bus.rob_csr_idx), 64'(mq[0].csr_idx));
      check("rob_csr_data", 64'(bus.rob_csr_data), 64'(mq[0].csr_data));
      check("rob_fence_i_op", 64'(bus.rob_fence_i_op), 64'(mq[0].fence_i));
      check("rob_mret_op", 64'(bus.rob_mret_op), 64'(mq[0].mret));
      check("rob_next_pc", 64'(bus.rob_next_pc), 64'(mq[0].next_pc));
      check("rob_info", 64'(bus.rob_info), 64'({mq[0].pc, mq[0].irq, mq[0].excp}));
    end
  endtask

  task automatic model_step();
    bit   do_commit, do_disp;
    ent_t e;
    if (bus.flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      do_commit = bus.rob_valid && (mq.size() > 0) && mq[0].done;
      do_disp   = bus.disp_valid && (mq.size() < DEPTH);
      if (bus.wb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(bus.wb_tag)) begin
            mq[i].done     = 1'b1;
            mq[i].rd_data  = bus.wb_rd_data;
            mq[i].csr_data = bus.wb_csr_data;
            mq[i].next_pc  = bus.wb_next_pc;
            mq[i].excp     = bus.wb_excp;
          end
        end
      end
      if (do_commit) void'(mq.pop_front());
      if (do_disp) begin
        e.tag      = m_tail;
        e.rd_need  = bus.disp_rd_need;
        e.rd_idx   = bus.disp_rd_idx;
        e.csr_need = bus.disp_csr_need;
        e.csr_idx  = bus.disp_csr_idx;
        e.fence_i  = bus.disp_fence_i_op;
        e.mret     = bus.disp_mret_op;
        e.pc       = bus.disp_pc;
        e.irq      = bus.disp_irq;
        e.rd_data  = '0;
        e.csr_data = '0;
        e.next_pc  = '0;
        e.excp     = '0;
        e.done     = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // Called just after a rising edge: compare at the falling edge, then advance model and DUT together.
  task automatic cycle();
    @(negedge clk);
    cmp_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.rob_valid  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic rand_payload();
    bus.disp_rd_need    = 1'($urandom_range(0, 1));
    bus.disp_rd_idx     = 5'($urandom);
    bus.disp_csr_need   = 1'($urandom_range(0, 1));
    bus.disp_csr_idx    = 12'($urandom);
    bus.disp_fence_i_op = 1'($urandom_range(0, 1));
    bus.disp_mret_op    = 1'($urandom_range(0, 1));
    bus.disp_pc         = $urandom;
    bus.disp_irq        = 1'($urandom_range(0, 1));
    bus.wb_tag          = 2'($urandom);
    bus.wb_rd_data      = $urandom;
    bus.wb_csr_data     = $urandom;
    bus.wb_next_pc      = $urandom;
    bus.wb_excp         = 4'($urandom);
  endtask

  task automatic reset_pulse();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulse_rob_ready", 64'(bus.rob_ready), 64'd0);
    check("rst_pulse_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("rst_pulse_rob_info", 64'(bus.rob_info), 64'd0);
    check("rst_pulse_rob_rd_data", 64'(bus.rob_rd_data), 64'd0);
    #1 rst_n = 1'b1;
    mq.delete();
    m_tail = 0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_tail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    rand_payload();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_rob_ready", 64'(bus.rob_ready), 64'd0);
    check("reset_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("reset_disp_tag", 64'(bus.disp_tag), 64'd0);
    check("reset_rob_info", 64'(bus.rob_info), 64'd0);

    // Fill without writeback: tags 0..3, then refuse a fifth.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      rand_payload();
      bus.disp_valid = 1'b1;
      check("fill_tag", 64'(bus.disp_tag), 64'(i));
      cycle();
    end
    check("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    idle_inputs();
    bus.disp_valid = 1'b1;
    cycle();
    check("fifth_not_taken_ready", 64'(bus.disp_ready), 64'd0);
    check("fifth_not_taken_tag", 64'(bus.disp_tag), 64'd0);

    // Full with complete head: commit and dispatch together, dispatch must wait.
    idle_inputs();
    rand_payload();
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 2'd0;
    cycle();
    check("full_head_ready", 64'(bus.rob_ready), 64'd1);
    idle_inputs();
    bus.rob_valid  = 1'b1;
    bus.disp_valid = 1'b1;
    check("full_commit_disp_ready", 64'(bus.disp_ready), 64'd0);
    cycle();
    check("wrap_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("wrap_disp_tag", 64'(bus.disp_tag), 64'd0);
    idle_inputs();
    bus.flush = 1'b1;
    cycle();

    // Out-of-order writeback, in-order commit on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      rand_payload();
      bus.disp_valid = 1'b1;
      cycle();
    end
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_tag = 2'd2; bus.wb_rd_data = 32'h22;
    cycle();
    check("ooo_wait_ready", 64'(bus.rob_ready), 64'd0);
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_tag = 2'd0; bus.wb_rd_data = 32'h00;
    cycle();
    check("ooo_head_ready", 64'(bus.rob_ready), 64'd1);
    check("ooo_commit0", 64'(bus.rob_rd_data), 64'h00);
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_tag = 2'd1; bus.wb_rd_data = 32'h11;
    bus.rob_valid = 1'b1;
    cycle();
    check("ooo_ready1", 64'(bus.rob_ready), 64'd1);
    check("ooo_commit1", 64'(bus.rob_rd_data), 64'h11);
    idle_inputs();
    bus.rob_valid = 1'b1;
    cycle();
    check("ooo_ready2", 64'(bus.rob_ready), 64'd1);
    check("ooo_commit2", 64'(bus.rob_rd_data), 64'h22);
    cycle();
    check("ooo_empty", 64'(bus.rob_ready), 64'd0);

    // Flush with dispatch and writeback in the same cycle.
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      bus.disp_valid = 1'b1;
      cycle();
    end
    idle_inputs();
    bus.flush = 1'b1; bus.disp_valid = 1'b1; bus.wb_valid = 1'b1; bus.wb_tag = 2'd0;
    cycle();
    check("flush_rob_ready", 64'(bus.rob_ready), 64'd0);
    check("flush_disp_tag", 64'(bus.disp_tag), 64'd0);
    check("flush_disp_ready", 64'(bus.disp_ready), 64'd1);

    // Asynchronous reset with two complete entries.
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      rand_payload();
      bus.disp_valid = 1'b1;
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      rand_payload();
      bus.wb_valid = 1'b1;
      bus.wb_tag   = 2'(i);
      cycle();
    end
    idle_inputs();
    check("pre_rst_ready", 64'(bus.rob_ready), 64'd1);
    reset_pulse();
    bus.rob_valid = 1'b1;
    cycle();
    check("post_rst_ready", 64'(bus.rob_ready), 64'd0);
    check("post_rst_tag", 64'(bus.disp_tag), 64'd0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) reset_pulse();
      idle_inputs();
      rand_payload();
      bus.disp_valid = ($urandom_range(0, 99) < 55);
      bus.rob_valid  = ($urandom_range(0, 99) < 70);
      bus.flush      = ($urandom_range(0, 99) < 2);
      bus.wb_valid   = ($urandom_range(0, 99) < 60);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        bus.wb_tag = 2'(mq[$urandom_range(0, mq.size() - 1)].tag);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
